chip8_sound_timer: RTL and testbench

- Implements the Chip8 sound timer (ST) register and the beep it drives.
- The CPU loads ST through Fx18. The block decrements ST at 60 Hz and produces an envelope-shaped square-wave sample stream in response to codec sample requests.
- It drives the is_on control consumed by the sound controller.
- It sits between the CPU register file and the audio datapath. Linear ramp-up and ramp-down of amplitude remove clicks at beep start and end.

---
 rtl/chip8_sound_timer.sv | 163 ++++++++++++++++
 tb/tb_chip8_sound_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sound_timer.sv
`timescale 1ns/1ps
// Chip8 sound timer: 60 Hz ST countdown driving a click-free, envelope-shaped square-wave beep.
// Samples return one cycle after sample_req; there is no backpressure, every request is answered.
module chip8_sound_timer #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned TICK_HZ     = 60,
    parameter int unsigned HALF_PERIOD = 50,
    parameter logic [15:0] AMPLITUDE   = 16'h2000,
    parameter logic [15:0] RAMP_STEP   = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_we,
    input  logic [7:0]  st_wdata,
    input  logic        pause,
    input  logic        sample_req,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        is_on,
    output logic [7:0]  st_value,
    output logic        tick
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned HW  = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [HW-1:0] PH_LAST    = HW'(HALF_PERIOD - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_SUSTAIN   = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [7:0]    st_q, st_d;
    logic [1:0]    state_q, state_d;
    logic          on_q, on_d;
    logic [15:0]   env_q, env_d;
    logic [HW-1:0] ph_cnt_q, ph_cnt_d;
    logic          ph_bit_q, ph_bit_d;
    logic [15:0]   sample_q, sample_d;
    logic          valid_q, valid_d;

    logic          presc_wrap;
    logic          st_zero;
    logic [16:0]   env_up_sum;
    logic [15:0]   env_up;
    logic [15:0]   env_dn;

    always_comb begin
        presc_wrap = !pause && (presc_q == PRESC_LAST);
        presc_d    = presc_q;
        if (presc_wrap) begin
            presc_d = '0;
        end else if (!pause) begin
            presc_d = presc_q + PW'(1);
        end
        tick_d = presc_wrap;
    end

    // Write beats the decrement; zero is sticky so ST never wraps.
    always_comb begin
        st_d = st_q;
        if (st_we) begin
            st_d = st_wdata;
        end else if (tick_q && (st_q != 8'd0)) begin
            st_d = st_q - 8'd1;
        end
    end

    assign st_zero = (st_q == 8'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!st_zero) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (st_zero)                 state_d = S_RAMP_DOWN;
                else if (env_q == AMPLITUDE) state_d = S_SUSTAIN;
            end
            S_SUSTAIN: begin
                if (st_zero) state_d = S_RAMP_DOWN;
            end
            default: begin
                if (!st_zero)            state_d = S_RAMP_UP;
                else if (env_q == 16'd0) state_d = S_IDLE;
            end
        endcase
        on_d = (state_d != S_IDLE);
    end

    // Ramp arithmetic is done one bit wider so the up-ramp saturates instead of wrapping.
    always_comb begin
        env_up_sum = {1'b0, env_q} + {1'b0, RAMP_STEP};
        env_up     = (env_up_sum >= {1'b0, AMPLITUDE}) ? AMPLITUDE : env_up_sum[15:0];
        env_dn     = (env_q <= RAMP_STEP) ? 16'd0 : (env_q - RAMP_STEP);
    end

    always_comb begin
        env_d    = env_q;
        ph_cnt_d = ph_cnt_q;
        ph_bit_d = ph_bit_q;
        sample_d = sample_q;
        valid_d  = sample_req;
        if (sample_req) begin
            sample_d = ph_bit_q ? (16'd0 - env_q) : env_q;
            case (state_q)
                S_RAMP_UP:   env_d = env_up;
                S_SUSTAIN:   env_d = AMPLITUDE;
                S_RAMP_DOWN: env_d = env_dn;
                default:     env_d = 16'd0;
            endcase
            if (state_q != S_IDLE) begin
                if (ph_cnt_q == PH_LAST) begin
                    ph_cnt_d = '0;
                    ph_bit_d = !ph_bit_q;
                end else begin
                    ph_cnt_d = ph_cnt_q + HW'(1);
                end
            end
        end
        if (state_q == S_IDLE) begin
            ph_cnt_d = '0;
            ph_bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            st_q     <= 8'd0;
            state_q  <= S_IDLE;
            on_q     <= 1'b0;
            env_q    <= 16'd0;
            ph_cnt_q <= '0;
            ph_bit_q <= 1'b0;
            sample_q <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            st_q     <= st_d;
            state_q  <= state_d;
            on_q     <= on_d;
            env_q    <= env_d;
            ph_cnt_q <= ph_cnt_d;
            ph_bit_q <= ph_bit_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign is_on        = on_q;
    assign st_value     = st_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_chip8_sound_timer.sv
`timescale 1ns/1ps
// Bench for chip8_sound_timer: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the timer, envelope and tone position.
module tb_chip8_sound_timer;
    localparam int DIV  = 10;
    localparam int HP   = 4;
    localparam int AMP  = 32'h0400;
    localparam int STEP = 32'h0100;
    localparam int MD_IDLE = 0, MD_UP = 1, MD_SUS = 2, MD_DOWN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_we = 1'b0;
    logic [7:0]  st_wdata = 8'd0;
    logic        pause = 1'b0;
    logic        sample_req = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        is_on;
    logic [7:0]  st_value;
    logic        tick;

    int checks = 0;
    int failures = 0;

    int m_presc, m_st, m_mode, m_env, m_pos, m_sample, m_tick, m_valid, m_on;

    chip8_sound_timer #(
        .CLK_HZ(600), .TICK_HZ(60), .HALF_PERIOD(4),
        .AMPLITUDE(16'h0400), .RAMP_STEP(16'h0100)
    ) dut (
        .clk(clk), .reset(reset), .st_we(st_we), .st_wdata(st_wdata),
        .pause(pause), .sample_req(sample_req), .sample_out(sample_out),
        .sample_valid(sample_valid), .is_on(is_on), .st_value(st_value), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_st = 0; m_mode = MD_IDLE; m_env = 0; m_pos = 0;
        m_sample = 0; m_tick = 0; m_valid = 0; m_on = 0;
    endtask

    // Tone position counts samples within one full cycle of 2*HP; upper half is negative.
    task automatic model_step(input bit we, input int wd, input bit p, input bit rq);
        int n_presc, n_tick, n_st, n_mode, n_env, n_pos, n_sample;
        n_tick  = (!p && m_presc == DIV - 1) ? 1 : 0;
        n_presc = p ? m_presc : (m_presc + 1) % DIV;
        if (we)                      n_st = wd;
        else if (m_tick == 1 && m_st > 0) n_st = m_st - 1;
        else                         n_st = m_st;
        n_mode = m_mode;
        case (m_mode)
            MD_IDLE: if (m_st != 0) n_mode = MD_UP;
            MD_UP:   if (m_st == 0) n_mode = MD_DOWN; else if (m_env == AMP) n_mode = MD_SUS;
            MD_SUS:  if (m_st == 0) n_mode = MD_DOWN;
            default: if (m_st != 0) n_mode = MD_UP; else if (m_env == 0) n_mode = MD_IDLE;
        endcase
        n_env = m_env; n_pos = m_pos; n_sample = m_sample;
        if (rq) begin
            n_sample = (((m_pos / HP) % 2) == 1) ? ((65536 - m_env) % 65536) : m_env;
            case (m_mode)
                MD_UP:   n_env = (m_env + STEP > AMP) ? AMP : m_env + STEP;
                MD_SUS:  n_env = AMP;
                MD_DOWN: n_env = (m_env < STEP) ? 0 : m_env - STEP;
                default: n_env = 0;
            endcase
            n_pos = (m_pos + 1) % (2 * HP);
        end
        if (m_mode == MD_IDLE) n_pos = 0;
        m_presc = n_presc; m_tick = n_tick; m_st = n_st; m_mode = n_mode;
        m_env = n_env; m_pos = n_pos; m_sample = n_sample;
        m_valid = rq ? 1 : 0;
        m_on = (n_mode != MD_IDLE) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("tick", 32'(tick), m_tick);
        chk("st_value", 32'(st_value), m_st);
        chk("is_on", 32'(is_on), m_on);
        chk("sample_valid", 32'(sample_valid), m_valid);
        chk("sample_out", 32'(sample_out), m_sample);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_st"}, 32'(st_value), 0);
        chk({tag, "_on"}, 32'(is_on), 0);
        chk({tag, "_valid"}, 32'(sample_valid), 0);
        chk({tag, "_sample"}, 32'(sample_out), 0);
    endtask

    task automatic step(input bit we, input int wd, input bit p, input bit rq);
        st_we = we; st_wdata = 8'(wd); pause = p; sample_req = rq;
        @(posedge clk);
        model_step(we, wd, p, rq);
        @(negedge clk);
        st_we = 1'b0; sample_req = 1'b0;
        check_all();
    endtask

    initial begin
        int tick_at[$];
        int seen[$];
        int n;
        int v;
        logic [15:0] got[$];
        logic [15:0] exp3[12];
        logic [15:0] exp5[4];
        logic [15:0] exp5b[9];

        exp3  = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hFC00, 16'hFC00,
                  16'hFC00, 16'hFC00, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
        exp5  = '{16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00};
        exp5b = '{16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0200,
                  16'h0300, 16'h0400, 16'h0400, 16'h0400};
        model_reset();

        // Reset held: inputs toggling, outputs pinned low.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            st_we = 1'($urandom); st_wdata = 8'($urandom); pause = 1'($urandom);
            sample_req = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_zero("rst_hold");
        end
        st_we = 1'b0; st_wdata = 8'd0; pause = 1'b0; sample_req = 1'b0;
        reset = 1'b1;

        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 0, 0);
            if (tick) tick_at.push_back(i);
        end
        chk("tick_count", 32'(tick_at.size()), 3);
        for (int k = 0; k < tick_at.size(); k++) chk("tick_at", 32'(tick_at[k]), 32'(10 * (k + 1)));

        // Countdown from 3 with no sample requests.
        step(1, 3, 0, 0);
        chk("t2_written", 32'(st_value), 3);
        chk("t2_on_before", 32'(is_on), 0);
        seen.push_back(int'(st_value));
        step(0, 0, 0, 0);
        chk("t2_on_rise", 32'(is_on), 1);
        for (int i = 0; i < 45; i++) begin
            step(0, 0, 0, 0);
            if (int'(st_value) != seen[seen.size() - 1]) seen.push_back(int'(st_value));
        end
        chk("t2_seq_len", 32'(seen.size()), 4);
        for (int k = 0; k < seen.size(); k++) chk("t2_seq", 32'(seen[k]), 32'(3 - k));
        chk("t2_on_fall", 32'(is_on), 0);

        // Write coincident with tick, then pause.
        n = 0;
        while (!tick && n < 20) begin step(0, 0, 0, 0); n++; end
        chk("t4_tick_seen", 32'(tick), 1);
        step(1, 5, 0, 0);
        chk("t4_we_priority", 32'(st_value), 5);
        v = int'(st_value);
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 1, 0);
            chk("t4_pause_tick", 32'(tick), 0);
            chk("t4_pause_st", 32'(st_value), 32'(v));
        end
        step(0, 0, 0, 0);

        // Ramp up into sustain, tone polarity flip.
        step(1, 255, 0, 0);
        step(0, 0, 0, 0);
        chk("t3_on", 32'(is_on), 1);
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 1);
            chk("t3_valid", 32'(sample_valid), 1);
            got.push_back(sample_out);
            step(0, 0, 0, 0);
            chk("t3_valid_drop", 32'(sample_valid), 0);
        end
        for (int k = 0; k < 12; k++) chk("t3_sample", 32'(got[k]), 32'(exp3[k]));

        // Ramp down to idle from sustain.
        step(1, 1, 0, 0);
        n = 0;
        while (st_value != 8'd0 && n < 40) begin step(0, 0, 0, 0); n++; end
        chk("t5_st_zero", 32'(st_value), 0);
        step(0, 0, 0, 0);
        got.delete();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1);
            got.push_back(sample_out);
            chk("t5_on_req", 32'(is_on), 1);
            step(0, 0, 0, 0);
            chk("t5_on", 32'(is_on), (k == 3) ? 0 : 1);
        end
        for (int k = 0; k < 4; k++) chk("t5_sample", 32'(got[k]), 32'(exp5[k]));

        // Rewrite during ramp down: envelope resumes from where it was.
        step(1, 3, 0, 0);
        step(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
        n = 0;
        while (st_value != 8'd0 && n < 60) begin step(0, 0, 0, 0); n++; end
        chk("t5b_st_zero", 32'(st_value), 0);
        step(0, 0, 0, 0);
        got.delete();
        for (int k = 0; k < 9; k++) begin
            step((k == 2), 9, 0, 1);
            got.push_back(sample_out[15] ? (16'd0 - sample_out) : sample_out);
            chk("t5b_on", 32'(is_on), 1);
            step(0, 0, 0, 0);
        end
        for (int k = 0; k < 9; k++) chk("t5b_mag", 32'(got[k]), 32'(exp5b[k]));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end

        // Async reset in the middle of a ramp-up.
        step(1, 0, 0, 0);
        n = 0;
        while (is_on && n < 100) begin step(0, 0, 0, 1); n++; end
        chk("t6_idle", 32'(is_on), 0);
        step(1, 50, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t6_pre_sample", 32'(sample_out), 32'h0100);
        chk("t6_pre_on", 32'(is_on), 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("t6_async");
        model_reset();
        @(negedge clk);
        check_zero("t6_held");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
